// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_pkg
//  Description : Frame layout constants, FSM state encoding and a byte
//                extraction helper shared by USBReader, USBSender and the
//                receive-side frame decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    localparam int FRAME_W   = 11;
    localparam int START_BIT = 10;
    localparam int DATA_MSB  = 9;
    localparam int DATA_LSB  = 2;
    localparam int PAR_BIT   = 1;
    localparam int STOP_BIT  = 0;

    // Decoder sequencing: one frame walks IDLE -> CHECK -> PUSH/REJECT -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_PUSH   = 2'd2,
        ST_REJECT = 2'd3
    } dec_state_t;

    // Data goes out LSB first, so the frame's top data bit is byte bit 0
    function automatic logic [7:0] frame_to_byte(input logic [FRAME_W-1:0] frame);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i <= DATA_MSB - DATA_LSB; i++) begin
            b[i] = frame[DATA_MSB - i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : usb_byte_fifo
//  Description : First-word fall-through byte FIFO with circular pointers and
//                an explicit occupancy counter. A pop in the same cycle as a
//                push makes room for it, even when the FIFO is full.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [7:0]               i_wr_data,
    input  logic                     i_rd_en,
    output logic                     o_wr_accept,
    output logic                     o_valid,
    output logic [7:0]               o_data,
    output logic [$clog2(DEPTH):0]   o_fill
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_FILL_W = $clog2(DEPTH) + 1;

    logic [7:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_FILL_W-1:0] r_fill;

    logic w_full;
    logic w_rd_fire;
    logic w_wr_fire;

    assign w_full      = (r_fill == c_FILL_W'(DEPTH));
    assign w_rd_fire   = i_rd_en && (r_fill != '0);
    // The pop frees a slot before the push is considered
    assign o_wr_accept = !w_full || w_rd_fire;
    assign w_wr_fire   = i_wr_en && o_wr_accept;

    // Storage array; cleared on reset so the head reads zero when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_wr_fire, w_rd_fire})
                2'b10:   r_fill <= r_fill + c_FILL_W'(1);
                2'b01:   r_fill <= r_fill - c_FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign o_valid = (r_fill != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_fill  = r_fill;

endmodule
`default_nettype wire

// File: rtl/usb_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : usb_frame_decoder
//  Description : Takes each 11-bit frame from USBReader on the rising edge of
//                word_ready, checks start/stop/odd parity, queues good bytes
//                in a small FIFO and keeps sticky error flags plus a
//                saturating rejected-frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_frame_decoder
    import usb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   ck,
    input  logic                   reset,
    input  logic                   word_ready,
    input  logic [FRAME_W-1:0]     word,
    output logic                   byte_valid,
    output logic [7:0]             byte_data,
    input  logic                   byte_ready,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   overrun,
    output logic [CNT_W-1:0]       err_count,
    input  logic                   clear_err,
    output logic [$clog2(DEPTH):0] fill
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    dec_state_t          r_state;
    dec_state_t          w_state_next;
    logic                r_word_ready_d;
    logic [FRAME_W-1:0]  r_frame;

    logic w_rise;
    logic w_latch;
    logic w_push_req;
    logic w_start_ok;
    logic w_stop_ok;
    logic w_par_ok;
    logic w_frame_ok;
    logic w_fifo_accept;
    logic w_rej_evt;
    logic w_ovr_evt;
    logic w_err_evt;

    logic                r_frame_err;
    logic                r_parity_err;
    logic                r_overrun;
    logic [CNT_W-1:0]    r_err_count;

    assign w_rise     = word_ready && !r_word_ready_d;
    assign w_start_ok = !r_frame[START_BIT];
    assign w_stop_ok  = r_frame[STOP_BIT];
    assign w_par_ok   = ^r_frame[DATA_MSB:PAR_BIT];
    assign w_frame_ok = w_start_ok && w_stop_ok && w_par_ok;

    // Edge-detect register and frame capture
    always_ff @(posedge ck) begin
        if (reset) begin
            r_word_ready_d <= 1'b0;
            r_frame        <= '0;
        end else begin
            r_word_ready_d <= word_ready;
            if (w_latch) begin
                r_frame <= word;
            end
        end
    end

    // FSM state register
    always_ff @(posedge ck) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state strobes; edges seen outside IDLE are dropped
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_push_req   = 1'b0;
        w_rej_evt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_state_next = w_frame_ok ? ST_PUSH : ST_REJECT;
            end
            ST_PUSH: begin
                w_push_req   = 1'b1;
                w_state_next = ST_IDLE;
            end
            ST_REJECT: begin
                w_rej_evt    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_ovr_evt = w_push_req && !w_fifo_accept;
    assign w_err_evt = w_ovr_evt || w_rej_evt;

    // Sticky flags and counter; a same-cycle error beats clear_err
    always_ff @(posedge ck) begin
        if (reset) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_err_count  <= '0;
        end else begin
            if (clear_err) begin
                r_frame_err  <= 1'b0;
                r_parity_err <= 1'b0;
                r_overrun    <= 1'b0;
                r_err_count  <= '0;
            end
            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end
            if (w_rej_evt && (!w_start_ok || !w_stop_ok)) begin
                r_frame_err <= 1'b1;
            end
            if (w_rej_evt && !w_par_ok) begin
                r_parity_err <= 1'b1;
            end
            if (w_err_evt) begin
                if (clear_err) begin
                    r_err_count <= CNT_W'(1);
                end else if (r_err_count != c_CNT_MAX) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
            end
        end
    end

    usb_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (ck),
        .rst         (reset),
        .i_wr_en     (w_push_req),
        .i_wr_data   (frame_to_byte(r_frame)),
        .i_rd_en     (byte_ready),
        .o_wr_accept (w_fifo_accept),
        .o_valid     (byte_valid),
        .o_data      (byte_data),
        .o_fill      (fill)
    );

    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_usb_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_frame_decoder
//  Description : Self-checking bench for usb_frame_decoder: directed scenarios
//                with literal expectations, then randomized traffic compared
//                every cycle against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_frame_decoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic        ck         = 1'b0;
    logic        reset      = 1'b1;
    logic        word_ready = 1'b0;
    logic [10:0] word       = '0;
    logic        byte_ready = 1'b0;
    logic        clear_err  = 1'b0;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;
    logic [7:0]  err_count;
    logic [2:0]  fill;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 ck = ~ck;

    usb_frame_decoder #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .ck         (ck),
        .reset      (reset),
        .word_ready (word_ready),
        .word       (word),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .err_count  (err_count),
        .clear_err  (clear_err),
        .fill       (fill)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ck);
    endtask

    // Stimulus builder: byte goes on the wire LSB first, parity made odd
    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_start,
                                               input bit bad_stop, input bit bad_par);
        logic [10:0] f;
        f[10] = bad_start;
        for (int i = 0; i < 8; i++) f[9-i] = b[i];
        f[1] = ~(^b) ^ bad_par;
        f[0] = ~bad_stop;
        return f;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    function automatic bit m_good(input logic [10:0] w);
        return (w[10] == 1'b0) && (w[0] == 1'b1) && (($countones(w[9:1]) % 2) == 1);
    endfunction

    function automatic int m_byte(input logic [10:0] w);
        int v;
        v = 0;
        for (int k = 2; k <= 9; k++) v = v * 2 + int'(w[k]);
        return v;
    endfunction

    function automatic int m_sat(input int c);
        return (c + 1 > 255) ? 255 : c + 1;
    endfunction

    int          m_q[$];
    bit          m_ferr, m_perr, m_ovr;
    int          m_cnt;
    bit          m_pend;
    int          m_due;
    logic [10:0] m_pw;
    bit          m_prev_wr;
    int          cyc = 0;

    always @(posedge ck) begin
        bit busy;
        cyc++;
        if (reset) begin
            m_q.delete();
            m_ferr = 0; m_perr = 0; m_ovr = 0; m_cnt = 0;
            m_pend = 0; m_prev_wr = 0;
        end else begin
            busy = m_pend;
            if (byte_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (clear_err) begin
                m_ferr = 0; m_perr = 0; m_ovr = 0; m_cnt = 0;
            end
            if (m_pend && m_due == cyc) begin
                m_pend = 0;
                if (m_good(m_pw)) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_byte(m_pw));
                    else begin
                        m_ovr = 1;
                        m_cnt = m_sat(m_cnt);
                    end
                end else begin
                    if (m_pw[10] || !m_pw[0]) m_ferr = 1;
                    if (($countones(m_pw[9:1]) % 2) == 0) m_perr = 1;
                    m_cnt = m_sat(m_cnt);
                end
            end
            if (word_ready && !m_prev_wr && !busy) begin
                m_pend = 1;
                m_due  = cyc + 2;
                m_pw   = word;
            end
            m_prev_wr = word_ready;
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge ck) begin
        if (chk_en) begin
            check("m_fill", fill, m_q.size());
            check("m_byte_valid", byte_valid, m_q.size() != 0);
            if (m_q.size() != 0) check("m_byte_data", byte_data, m_q[0]);
            check("m_frame_err", frame_err, m_ferr);
            check("m_parity_err", parity_err, m_perr);
            check("m_overrun", overrun, m_ovr);
            check("m_err_count", err_count, m_cnt);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [10:0] f, input int hold, input int gap);
        word = f;
        word_ready = 1'b1;
        tick(hold);
        word_ready = 1'b0;
        tick(gap);
    endtask

    task automatic clear_pulse();
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
    endtask

    logic [7:0] ov[5];

    initial begin
        ov[0] = 8'h11; ov[1] = 8'h22; ov[2] = 8'h33; ov[3] = 8'h44; ov[4] = 8'h55;

        tick(3);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_valid", byte_valid, 0);
        check("rst_data", byte_data, 0);
        check("rst_fill", fill, 0);
        check("rst_flags", {frame_err, parity_err, overrun}, 0);
        check("rst_count", err_count, 0);

        // Good frame: visible 3 cycles after the rising edge
        word = 11'b01010110101;
        word_ready = 1'b1;
        tick(1);
        word_ready = 1'b0;
        tick(1);
        check("good_latency", byte_valid, 0);
        tick(1);
        check("good_valid", byte_valid, 1);
        check("good_data", byte_data, 8'hB5);
        check("good_flags", {frame_err, parity_err, overrun}, 0);
        check("good_count", err_count, 0);
        byte_ready = 1'b1;
        tick(1);
        byte_ready = 1'b0;
        check("good_popped", byte_valid, 0);

        // Parity error, then clear
        send_frame(11'b01010110111, 1, 3);
        check("par_parity_err", parity_err, 1);
        check("par_frame_err", frame_err, 0);
        check("par_count", err_count, 1);
        check("par_no_push", byte_valid, 0);
        clear_pulse();
        check("par_cleared", {frame_err, parity_err, overrun, err_count}, 0);

        // Framing error
        send_frame(11'b11010110100, 1, 3);
        check("frm_frame_err", frame_err, 1);
        check("frm_parity_err", parity_err, 0);
        check("frm_count", err_count, 1);
        check("frm_fill", fill, 0);
        clear_pulse();

        // Overrun with word_ready held high
        for (int i = 0; i < 5; i++) send_frame(make_frame(ov[i], 0, 0, 0), 20, 3);
        check("ovr_fill", fill, 4);
        check("ovr_flag", overrun, 1);
        check("ovr_count", err_count, 1);
        byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovr_drain", byte_data, ov[i]);
            tick(1);
        end
        byte_ready = 1'b0;
        check("ovr_drained", byte_valid, 0);
        clear_pulse();

        // Push and pop in the same cycle while full
        for (int i = 0; i < 4; i++) send_frame(make_frame(8'hA1 + 8'(i), 0, 0, 0), 1, 3);
        word = make_frame(8'hA5, 0, 0, 0);
        word_ready = 1'b1;
        tick(1);
        word_ready = 1'b0;
        tick(1);
        byte_ready = 1'b1;
        tick(1);
        byte_ready = 1'b0;
        check("full_pp_fill", fill, 4);
        check("full_pp_overrun", overrun, 0);
        check("full_pp_head", byte_data, 8'hA2);

        // Reset while a frame sits in CHECK
        word = make_frame(8'h5A, 0, 0, 0);
        word_ready = 1'b1;
        tick(1);
        word_ready = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_valid", byte_valid, 0);
        check("midrst_data", byte_data, 0);
        check("midrst_fill", fill, 0);
        check("midrst_flags", {frame_err, parity_err, overrun, err_count}, 0);
        tick(3);
        check("midrst_discard", byte_valid, 0);

        // Counter saturation with 300 bad frames
        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            send_frame(make_frame(8'($urandom), kind == 0, kind == 1, kind == 2), 1, 3);
        end
        check("sat_count", err_count, 255);
        check("sat_no_push", byte_valid, 0);
        clear_pulse();
        check("sat_cleared", err_count, 0);

        // Randomized traffic with varying consumer pressure
        for (int c = 0; c < 4000; c++) begin
            int rp;
            rp = (c / 500) % 4;
            if (!word_ready && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 2) != 0)
                    word = make_frame(8'($urandom), 0, 0, 0);
                else
                    word = 11'($urandom);
                word_ready = 1'b1;
            end else if (word_ready && $urandom_range(0, 2) == 0) begin
                word_ready = 1'b0;
            end
            byte_ready = ($urandom_range(0, 3) < rp);
            clear_err  = ($urandom_range(0, 99) == 0);
            reset      = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        word_ready = 1'b0;
        byte_ready = 1'b0;
        clear_err  = 1'b0;
        reset      = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
